// File: rtl/led_counter_pkg.sv
// rtl/led_counter_pkg.sv - shared state encoding for the LED range counter
package led_counter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - prescaler producing one tick every PRESCALE enabled cycles
module led_tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == CW'(PRESCALE - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_range_counter.sv
// rtl/led_range_counter.sv - prescaled up/down range counter with one-shot and auto-reload
module led_range_counter
  import led_counter_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] start_num,
  input  logic [WIDTH-1:0] end_num,
  input  logic             up_down,
  input  logic             reload,
  input  logic             pause,
  output logic [WIDTH-1:0] counter_out,
  output logic             check,
  output logic             wrap,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] start_l_q, start_l_d;
  logic [WIDTH-1:0] end_l_q, end_l_d;
  logic             up_l_q, up_l_d;
  logic             reload_l_q, reload_l_d;
  logic             check_q, check_d;
  logic             wrap_q, wrap_d;
  logic             tick;
  logic             terminal;

  led_tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .enable ((state_q == ST_RUN) && !pause),
    .tick   (tick)
  );

  // Inclusive compare stops a start already past the end from stepping at all.
  assign terminal = up_l_q ? (count_q >= end_l_q) : (count_q <= end_l_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    start_l_d  = start_l_q;
    end_l_d    = end_l_q;
    up_l_d     = up_l_q;
    reload_l_d = reload_l_q;
    check_d    = check_q;
    wrap_d     = 1'b0;
    if (start) begin
      start_l_d  = start_num;
      end_l_d    = end_num;
      up_l_d     = up_down;
      reload_l_d = reload;
      count_d    = start_num;
      check_d    = 1'b0;
      state_d    = ST_RUN;
    end else if (state_q == ST_RUN && tick) begin
      if (!terminal) begin
        count_d = up_l_q ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end else if (reload_l_q) begin
        count_d = start_l_q;
        wrap_d  = 1'b1;
      end else begin
        check_d = 1'b1;
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      start_l_q  <= '0;
      end_l_q    <= '0;
      up_l_q     <= 1'b0;
      reload_l_q <= 1'b0;
      check_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      start_l_q  <= start_l_d;
      end_l_q    <= end_l_d;
      up_l_q     <= up_l_d;
      reload_l_q <= reload_l_d;
      check_q    <= check_d;
      wrap_q     <= wrap_d;
    end
  end

  assign counter_out = count_q;
  assign check       = check_q;
  assign wrap        = wrap_q;
  assign busy        = (state_q == ST_RUN);

endmodule

// File: tb/tb_led_range_counter.sv
// tb/tb_led_range_counter.sv - directed self-checking bench for led_range_counter
module tb_led_range_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       pause_a = 1'b0, pause_b = 1'b0;
  logic [4:0] start_num = '0, end_num = '0;
  logic       up_down = 1'b0, reload = 1'b0;
  logic [4:0] cnt_a, cnt_b;
  logic       chk_a, chk_b, wrap_a, wrap_b, busy_a, busy_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  led_range_counter #(.WIDTH(5), .PRESCALE(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .start_num(start_num), .end_num(end_num),
    .up_down(up_down), .reload(reload), .pause(pause_a),
    .counter_out(cnt_a), .check(chk_a), .wrap(wrap_a), .busy(busy_a)
  );

  led_range_counter #(.WIDTH(5), .PRESCALE(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .start_num(start_num), .end_num(end_num),
    .up_down(up_down), .reload(reload), .pause(pause_b),
    .counter_out(cnt_b), .check(chk_b), .wrap(wrap_b), .busy(busy_b)
  );

  task automatic load_a(input logic [4:0] s, input logic [4:0] e, input logic ud, input logic rl);
    start_num = s; end_num = e; up_down = ud; reload = rl; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic load_b(input logic [4:0] s, input logic [4:0] e, input logic ud, input logic rl);
    start_num = s; end_num = e; up_down = ud; reload = rl; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (cnt_a !== 5'd0) $display("FAIL reset_cnt got %0d exp 0", cnt_a); else passed++;
    total++; if (chk_a !== 1'b0) $display("FAIL reset_check got %b exp 0", chk_a); else passed++;
    total++; if (wrap_a !== 1'b0) $display("FAIL reset_wrap got %b exp 0", wrap_a); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_a); else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy_a !== 1'b0 || cnt_a !== 5'd0) $display("FAIL idle_wait busy=%b cnt=%0d exp 0/0", busy_a, cnt_a); else passed++;
  endtask

  task automatic test_oneshot_up();
    logic [4:0] exp_v;
    load_a(5'd3, 5'd7, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      exp_v = 5'd3 + 5'(i);
      total++; if (cnt_a !== exp_v || busy_a !== 1'b1 || chk_a !== 1'b0)
        $display("FAIL up_step%0d cnt=%0d busy=%b chk=%b exp %0d/1/0", i, cnt_a, busy_a, chk_a, exp_v);
      else passed++;
      @(negedge clk);
    end
    total++; if (chk_a !== 1'b1 || busy_a !== 1'b0 || cnt_a !== 5'd7)
      $display("FAIL up_done chk=%b busy=%b cnt=%0d exp 1/0/7", chk_a, busy_a, cnt_a);
    else passed++;
    repeat (2) @(negedge clk);
    total++; if (chk_a !== 1'b1 || cnt_a !== 5'd7) $display("FAIL up_hold chk=%b cnt=%0d exp 1/7", chk_a, cnt_a); else passed++;
  endtask

  task automatic test_reload_down();
    logic [4:0] exp_seq [9];
    logic       exp_wrap;
    exp_seq = '{5'd20, 5'd19, 5'd18, 5'd17, 5'd20, 5'd19, 5'd18, 5'd17, 5'd20};
    load_a(5'd20, 5'd17, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      exp_wrap = (i == 4 || i == 8);
      total++; if (cnt_a !== exp_seq[i] || wrap_a !== exp_wrap || busy_a !== 1'b1 || chk_a !== 1'b0)
        $display("FAIL reload_step%0d cnt=%0d wrap=%b busy=%b chk=%b exp %0d/%b/1/0",
                 i, cnt_a, wrap_a, busy_a, chk_a, exp_seq[i], exp_wrap);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_prescale_pause();
    logic [4:0] exp_v;
    logic       exp_c;
    load_b(5'd0, 5'd2, 1'b1, 1'b0);
    // values 0 x4, 1 x(4+3 paused), 2 x4, then check
    for (int k = 1; k <= 17; k++) begin
      if (k == 6) pause_b = 1'b1;
      if (k == 9) pause_b = 1'b0;
      exp_v = (k <= 4) ? 5'd0 : (k <= 11) ? 5'd1 : 5'd2;
      exp_c = (k >= 16);
      total++; if (cnt_b !== exp_v || chk_b !== exp_c || busy_b !== !exp_c)
        $display("FAIL presc_cyc%0d cnt=%0d chk=%b busy=%b exp %0d/%b/%b", k, cnt_b, chk_b, busy_b, exp_v, exp_c, !exp_c);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_edge_range();
    load_a(5'd30, 5'd31, 1'b1, 1'b0);
    total++; if (cnt_a !== 5'd30) $display("FAIL edge_30 got %0d exp 30", cnt_a); else passed++;
    @(negedge clk);
    total++; if (cnt_a !== 5'd31 || chk_a !== 1'b0) $display("FAIL edge_31 cnt=%0d chk=%b exp 31/0", cnt_a, chk_a); else passed++;
    @(negedge clk);
    total++; if (cnt_a !== 5'd31 || chk_a !== 1'b1) $display("FAIL edge_done cnt=%0d chk=%b exp 31/1", cnt_a, chk_a); else passed++;
    load_a(5'd31, 5'd0, 1'b1, 1'b0);
    total++; if (cnt_a !== 5'd31 || chk_a !== 1'b0 || busy_a !== 1'b1)
      $display("FAIL past_load cnt=%0d chk=%b busy=%b exp 31/0/1", cnt_a, chk_a, busy_a);
    else passed++;
    @(negedge clk);
    total++; if (cnt_a !== 5'd31 || chk_a !== 1'b1 || wrap_a !== 1'b0 || busy_a !== 1'b0)
      $display("FAIL past_term cnt=%0d chk=%b wrap=%b busy=%b exp 31/1/0/0", cnt_a, chk_a, wrap_a, busy_a);
    else passed++;
    @(negedge clk);
    total++; if (cnt_a !== 5'd31) $display("FAIL past_hold got %0d exp 31", cnt_a); else passed++;
  endtask

  task automatic test_restart();
    load_a(5'd5, 5'd9, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    total++; if (cnt_a !== 5'd7) $display("FAIL restart_pre got %0d exp 7", cnt_a); else passed++;
    load_a(5'd2, 5'd0, 1'b0, 1'b0);
    total++; if (cnt_a !== 5'd2 || chk_a !== 1'b0 || busy_a !== 1'b1)
      $display("FAIL restart_load cnt=%0d chk=%b busy=%b exp 2/0/1", cnt_a, chk_a, busy_a);
    else passed++;
    @(negedge clk);
    total++; if (cnt_a !== 5'd1) $display("FAIL restart_1 got %0d exp 1", cnt_a); else passed++;
    @(negedge clk);
    total++; if (cnt_a !== 5'd0 || chk_a !== 1'b0) $display("FAIL restart_0 cnt=%0d chk=%b exp 0/0", cnt_a, chk_a); else passed++;
    @(negedge clk);
    total++; if (cnt_a !== 5'd0 || chk_a !== 1'b1 || busy_a !== 1'b0)
      $display("FAIL restart_done cnt=%0d chk=%b busy=%b exp 0/1/0", cnt_a, chk_a, busy_a);
    else passed++;
  endtask

  task automatic test_async_reset();
    load_a(5'd0, 5'd31, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    total++; if (cnt_a !== 5'd5 || busy_a !== 1'b1) $display("FAIL arst_pre cnt=%0d busy=%b exp 5/1", cnt_a, busy_a); else passed++;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (cnt_a !== 5'd0 || chk_a !== 1'b0 || busy_a !== 1'b0 || wrap_a !== 1'b0)
      $display("FAIL arst_now cnt=%0d chk=%b busy=%b wrap=%b exp 0/0/0/0", cnt_a, chk_a, busy_a, wrap_a);
    else passed++;
    total++; if (chk_b !== 1'b0 || cnt_b !== 5'd0) $display("FAIL arst_b chk=%b cnt=%0d exp 0/0", chk_b, cnt_b); else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (cnt_a !== 5'd0 || busy_a !== 1'b0 || chk_a !== 1'b0)
      $display("FAIL arst_idle cnt=%0d busy=%b chk=%b exp 0/0/0", cnt_a, busy_a, chk_a);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_oneshot_up();
    test_reload_down();
    test_prescale_pause();
    test_edge_range();
    test_restart();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/led_range_counter.md
# led_range_counter

Parametrised up/down range counter for the LED display path. It loads a programmable start value, steps toward a programmable end value at a prescaled rate, and either stops with a done flag or reloads and repeats. It generalises the fixed 5-bit LED counter with parametrised width and step rate, latched range and direction, one-shot and auto-reload modes, pause, and a clean start handshake. It sits between the control/register logic and the LED/7-segment driver.

## Interface
Parameters:
- WIDTH, 5, counter and range width in bits (≥2)
- PRESCALE, 1, clock cycles per count step (≥1; 1 = step every cycle)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request: latch range/direction/mode, load start value, begin
- start_num  in  WIDTH  first value, sampled only on start
- end_num  in  WIDTH  terminal value, sampled only on start
- up_down  in  1  1 = count up, 0 = count down, sampled only on start
- reload  in  1  1 = auto-reload at terminal, 0 = one-shot, sampled only on start
- pause  in  1  level; freezes counter and prescaler while high
- counter_out  out  WIDTH  current count
- check  out  1  terminal reached (one-shot); held until next start
- wrap  out  1  one-cycle pulse on each auto-reload
- busy  out  1  high in RUN

## Operation
- States: IDLE (after reset), RUN, DONE.
- Reset (async, any state): state=IDLE; counter_out=0, check=0, wrap=0, busy=0; prescaler=0; latched registers=0.
- start=1 in any state (highest priority after rst): latch start_num, end_num, up_down, reload; counter_out<=start_num; prescaler<=0; check<=0; wrap<=0; state<=RUN. A start during RUN restarts; a start during DONE rearms.
- RUN, on tick and pause=0:
  - terminal test: up: counter_out ≥ end_l; down: counter_out ≤ end_l.
  - not terminal: counter_out ±1.
  - terminal, reload_l=1: counter_out<=start_l, wrap=1 for one cycle, stay RUN.
  - terminal, reload_l=0: state<=DONE, check<=1, counter_out unchanged.
- Start already at or past the end in the counting direction: terminal on the first tick, no step taken.
- Arithmetic: counting never passes end_l. No overflow or underflow occurs for any range, including 0 and 2^WIDTH−1.
- pause=1: prescaler and counter_out hold, and no terminal action occurs. start still takes effect during pause.
- IDLE/DONE: counter_out holds, and tick and pause are ignored.
- busy = (state==RUN).

## Timing
- start sampled at edge N: counter_out=start_num, busy=1, and check=0 are visible after edge N.
- Tick: the prescaler counts 0..PRESCALE−1 in RUN with pause=0, and tick is asserted when it equals PRESCALE−1. The first step occurs PRESCALE cycles after the load edge.
- Terminal at tick edge T: check/wrap rise after edge T. wrap falls after edge T+1.
- One-shot cycle count from load to check: (|end−start|+1)·PRESCALE cycles.
- All outputs are registered, with no combinational input→output paths.
- rst asserted mid-count: outputs go to reset values immediately, with no clock required. After deassertion, the block waits in IDLE for start.

## Structure
- Package led_counter_pkg: state encoding localparams (ST_IDLE, ST_RUN, ST_DONE), 2-bit state type.
- Sub-module led_tick_gen (parameter PRESCALE; ports clk, rst, clear, enable, tick). clear is driven by start, and enable by RUN & ~pause.
- The top module holds the FSM, latched range registers, and counter datapath.

## Test plan
- WIDTH=5, PRESCALE=1, start_num=3, end_num=7, up, one-shot → counter_out 3,4,5,6,7 on consecutive cycles; check=1 on the tick after 7 is reached; busy=0; counter_out holds 7.
- Down, start_num=20, end_num=17, reload=1 → 20,19,18,17,20,19…; one-cycle wrap pulse on each reload.
- PRESCALE=4, start 0 → end 2 up: each value held 4 cycles. Pause for 3 cycles mid-hold: hold is extended by exactly 3 cycles and no value is skipped.
- Edge range: up from 30 to 31, then 31 to 0 up (already past) → 30→31 then check; 31 sets check on the first tick, counter_out stays 31 with no wrap to 0.
- Restart: start(5→9 up) then start(2→0 down) at count 7 → counter_out=2 on the next cycle, counts down to 0, check=1.
- Async rst asserted mid-RUN between clock edges → counter_out=0, check=0, busy=0, wrap=0 immediately. No activity occurs until start.
